// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port 32-bit memory.
// Bounded-burst round robin; read data returns to the issuing port.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_write,
  input  logic [3:0]            a_wmask,
  input  logic [31:0]           a_wdata,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  output logic                  a_rvalid,
  output logic [31:0]           a_rdata,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_write,
  input  logic [3:0]            b_wmask,
  input  logic [31:0]           b_wdata,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic                  b_rvalid,
  output logic [31:0]           b_rdata,
  output logic                  mem_valid,
  output logic                  mem_write,
  output logic [3:0]            mem_wmask,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rdata
);

  localparam logic [CNT_WIDTH-1:0] MAXB = CNT_WIDTH'(MAX_BURST);
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

  logic                 last;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 rsel_a;
  logic                 rsel_b;
  logic                 gnt_a;
  logic                 gnt_b;
  logic                 sat;

  assign sat = (cnt >= MAXB);

  // Pick at most one port; last owner keeps it until its burst is spent.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!rst) begin
      unique case (1'b1)
        (a_valid && !b_valid): gnt_a = 1'b1;
        (!a_valid && b_valid): gnt_b = 1'b1;
        (a_valid && b_valid && !sat): begin
          gnt_a = !last;
          gnt_b = last;
        end
        (a_valid && b_valid && sat): begin
          gnt_a = last;
          gnt_b = !last;
        end
        default: ;
      endcase
    end
  end

  assign a_ready = gnt_a;
  assign b_ready = gnt_b;

  // Steer the granted request onto the memory bus; idle bus is all zero.
  always_comb begin
    mem_valid = 1'b0;
    mem_write = 1'b0;
    mem_wmask = '0;
    mem_wdata = '0;
    mem_addr  = '0;
    if (gnt_a) begin
      mem_valid = 1'b1;
      mem_write = a_write;
      mem_wmask = a_wmask;
      mem_wdata = a_wdata;
      mem_addr  = a_addr;
    end else if (gnt_b) begin
      mem_valid = 1'b1;
      mem_write = b_write;
      mem_wmask = b_wmask;
      mem_wdata = b_wdata;
      mem_addr  = b_addr;
    end
  end

  // Track burst owner and length; an idle cycle ends the burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b0;
      cnt  <= '0;
    end else if (gnt_a || gnt_b) begin
      if (gnt_b == last) begin
        cnt <= sat ? MAXB : cnt + ONE;
      end else begin
        last <= gnt_b;
        cnt  <= ONE;
      end
    end else begin
      cnt <= '0;
    end
  end

  // Remember which port owns next cycle's read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsel_a <= 1'b0;
      rsel_b <= 1'b0;
    end else begin
      rsel_a <= gnt_a && !a_write;
      rsel_b <= gnt_b && !b_write;
    end
  end

  assign a_rvalid = rsel_a;
  assign b_rvalid = rsel_b;
  assign a_rdata  = rsel_a ? mem_rdata : 32'h0;
  assign b_rdata  = rsel_b ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter.
// A second instance with MAX_BURST=1 is checked for grant order only.
module tb_mem_arbiter;

  typedef struct packed {
    logic        v;
    logic        w;
    logic [3:0]  m;
    logic [31:0] d;
    logic [31:0] a;
  } req_t;

  typedef struct packed {
    logic        ga;
    logic        gb;
    logic        w;
    logic [3:0]  m;
    logic [31:0] d;
    logic [31:0] a;
    logic        g1a;
    logic        g1b;
  } exp_t;

  typedef struct {
    int          due;
    logic [31:0] d;
  } rd_t;

  logic        clk;
  logic        rst;
  logic        a_valid, a_write, b_valid, b_write;
  logic [3:0]  a_wmask, b_wmask;
  logic [31:0] a_wdata, b_wdata, a_addr, b_addr;
  logic        a_ready, b_ready, a_rvalid, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_valid, mem_write;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata, mem_addr, mem_rdata;

  logic        a_ready1, b_ready1, a_rvalid1, b_rvalid1;
  logic [31:0] a_rdata1, b_rdata1;
  logic        mem_valid1, mem_write1;
  logic [3:0]  mem_wmask1;
  logic [31:0] mem_wdata1, mem_addr1;

  mem_arbiter #(.ADDR_WIDTH(32), .MAX_BURST(4), .CNT_WIDTH(3)) u_dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_write(a_write),
    .a_wmask(a_wmask), .a_wdata(a_wdata), .a_addr(a_addr),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_write(b_write),
    .b_wmask(b_wmask), .b_wdata(b_wdata), .b_addr(b_addr),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_WIDTH(32), .MAX_BURST(1), .CNT_WIDTH(3)) u_dut1 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready1), .a_write(a_write),
    .a_wmask(a_wmask), .a_wdata(a_wdata), .a_addr(a_addr),
    .a_rvalid(a_rvalid1), .a_rdata(a_rdata1),
    .b_valid(b_valid), .b_ready(b_ready1), .b_write(b_write),
    .b_wmask(b_wmask), .b_wdata(b_wdata), .b_addr(b_addr),
    .b_rvalid(b_rvalid1), .b_rdata(b_rdata1),
    .mem_valid(mem_valid1), .mem_write(mem_write1), .mem_wmask(mem_wmask1),
    .mem_wdata(mem_wdata1), .mem_addr(mem_addr1), .mem_rdata(32'h0)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 0;

  logic [31:0] tbm [2048];
  logic [31:0] refm [2048];

  exp_t gq[$];
  rd_t  qa[$];
  rd_t  qb[$];

  int ml0 = 0, mr0 = 0, ml1 = 0, mr1 = 0;
  req_t pa, pb;
  bit acc_a, acc_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // memory behaviour: read data appears one cycle after the strobe
  always @(posedge clk) begin
    if (mem_valid) begin
      if (mem_write) begin
        for (int i = 0; i < 4; i++)
          if (mem_wmask[i]) tbm[mem_addr[12:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
      end else begin
        mem_rdata <= tbm[mem_addr[12:2]];
      end
    end
  end

  // Reference arbitration: the current owner keeps priority until it has
  // had lim grants in a row; then the waiting port gets its turn.
  task automatic arb(input int lim, input bit av, input bit bv,
                     inout int last, inout int run,
                     output bit ga, output bit gb);
    bit own_keeps;
    own_keeps = (run < lim);
    ga = av && (!bv || ((last == 0) == own_keeps));
    gb = bv && !ga;
    if (ga || gb) begin
      if ((gb ? 1 : 0) == last) run = (run + 1 > lim) ? lim : run + 1;
      else begin
        last = gb ? 1 : 0;
        run  = 1;
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic access(input req_t r, inout rd_t q[$]);
    rd_t e;
    if (r.w) begin
      for (int i = 0; i < 4; i++)
        if (r.m[i]) refm[r.a[12:2]][8*i +: 8] = r.d[8*i +: 8];
    end else begin
      e.due = cyc + 1;
      e.d   = refm[r.a[12:2]];
      q.push_back(e);
    end
  endtask

  // Drive pa/pb for one cycle and record what must come out.
  task automatic step();
    exp_t e;
    bit ga, gb, g1a, g1b;
    cyc++;
    a_valid = pa.v; a_write = pa.w; a_wmask = pa.m;
    a_wdata = pa.d; a_addr = pa.a;
    b_valid = pb.v; b_write = pb.w; b_wmask = pb.m;
    b_wdata = pb.d; b_addr = pb.a;
    arb(4, pa.v, pb.v, ml0, mr0, ga, gb);
    arb(1, pa.v, pb.v, ml1, mr1, g1a, g1b);
    e = '0;
    e.ga = ga; e.gb = gb; e.g1a = g1a; e.g1b = g1b;
    if (ga) begin
      e.w = pa.w; e.m = pa.m; e.d = pa.d; e.a = pa.a;
      access(pa, qa);
    end else if (gb) begin
      e.w = pb.w; e.m = pb.m; e.d = pb.d; e.a = pb.a;
      access(pb, qb);
    end
    gq.push_back(e);
    acc_a = ga;
    acc_b = gb;
    chk_en = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    step();
  endtask

  function automatic req_t rd(input logic [31:0] addr);
    req_t r;
    r = '0;
    r.v = 1; r.a = addr; r.m = 4'($urandom_range(0, 15));
    return r;
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    r.v = ($urandom_range(0, 9) < 7);
    r.w = ($urandom_range(0, 2) == 0);
    r.m = 4'($urandom_range(0, 15));
    r.d = $urandom;
    r.a = {19'h0, 11'($urandom_range(0, 2047)), 2'b00};
    return r;
  endfunction

  // scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      rd_t  r;
      if (gq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL grant_queue: empty at cycle %0d", cyc);
      end else begin
        e = gq.pop_front();
        chk("a_ready", 64'(a_ready), 64'(e.ga));
        chk("b_ready", 64'(b_ready), 64'(e.gb));
        chk("mem_valid", 64'(mem_valid), 64'(e.ga | e.gb));
        chk("mem_addr", 64'(mem_addr), 64'(e.a));
        chk("mem_write", 64'(mem_write), 64'(e.w));
        chk("mem_wmask", 64'(mem_wmask), 64'(e.m));
        chk("mem_wdata", 64'(mem_wdata), 64'(e.d));
        chk("b1_a_ready", 64'(a_ready1), 64'(e.g1a));
        chk("b1_b_ready", 64'(b_ready1), 64'(e.g1b));
      end
      if (a_rvalid) begin
        if (qa.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL a_rvalid: got 1 expected 0 at cycle %0d", cyc);
        end else begin
          r = qa.pop_front();
          chk("a_rlat", 64'(cyc), 64'(r.due));
          chk("a_rdata", 64'(a_rdata), 64'(r.d));
        end
      end else begin
        chk("a_rdata_idle", 64'(a_rdata), 64'h0);
        if (qa.size() != 0 && qa[0].due <= cyc) begin
          n_chk++; n_fail++;
          $display("FAIL a_rvalid: got 0 expected 1 at cycle %0d", cyc);
          void'(qa.pop_front());
        end
      end
      if (b_rvalid) begin
        if (qb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL b_rvalid: got 1 expected 0 at cycle %0d", cyc);
        end else begin
          r = qb.pop_front();
          chk("b_rlat", 64'(cyc), 64'(r.due));
          chk("b_rdata", 64'(b_rdata), 64'(r.d));
        end
      end else begin
        chk("b_rdata_idle", 64'(b_rdata), 64'h0);
        if (qb.size() != 0 && qb[0].due <= cyc) begin
          n_chk++; n_fail++;
          $display("FAIL b_rvalid: got 0 expected 1 at cycle %0d", cyc);
          void'(qb.pop_front());
        end
      end
    end
  end

  initial begin
    int k;
    for (int i = 0; i < 2048; i++) begin
      tbm[i]  = 32'h1234_0000 ^ (i * 32'h0101_0101);
      refm[i] = tbm[i];
    end
    tbm[32'h40]  = 32'hDEAD_BEEF;
    refm[32'h40] = 32'hDEAD_BEEF;
    mem_rdata = 32'h0;

    rst = 1'b1;
    pa = '0; pa.v = 1; pb = '0; pb.v = 1;
    a_valid = 1; b_valid = 1;
    a_write = 0; b_write = 0; a_wmask = 0; b_wmask = 0;
    a_wdata = 0; b_wdata = 0; a_addr = 32'h10; b_addr = 32'h20;
    #7;
    chk("rst_a_ready", 64'(a_ready), 64'h0);
    chk("rst_b_ready", 64'(b_ready), 64'h0);
    chk("rst_mem_valid", 64'(mem_valid), 64'h0);
    chk("rst_mem_addr", 64'(mem_addr), 64'h0);
    chk("rst_a_rvalid", 64'(a_rvalid), 64'h0);
    chk("rst_b_rvalid", 64'(b_rvalid), 64'h0);
    a_valid = 0; b_valid = 0;
    pa = '0; pb = '0;
    #1 rst = 1'b0;

    // single read from A of the preloaded word
    pa = rd(32'h100);
    tick();
    pa = '0;
    tick();
    tick();

    // steady contention: bursts of four on the main instance
    pa = rd(32'h200);
    pb = rd(32'h300);
    for (int i = 0; i < 16; i++) tick();
    pa = '0; pb = '0;
    tick();

    // A streams reads, B arrives with a write mid-stream
    k = 0;
    pa = rd(32'h400);
    for (int i = 0; i < 16; i++) begin
      if (i == 6) begin
        pb = '0; pb.v = 1; pb.w = 1; pb.m = 4'hF;
        pb.d = 32'h1; pb.a = 32'h1000;
      end
      tick();
      if (acc_a) begin
        k++;
        pa = (k < 10) ? rd(32'h400 + 32'(4 * k)) : '0;
      end
      if (acc_b) pb = '0;
    end
    tick();

    // read on A then on B in consecutive cycles
    pa = rd(32'h0);
    tick();
    pa = '0;
    pb = rd(32'h4);
    tick();
    pb = '0;
    tick();
    tick();

    // read back what B wrote
    pb = rd(32'h1000);
    tick();
    pb = '0;
    tick();

    // randomized traffic with hold-until-ready requesters
    for (int i = 0; i < 3000; i++) begin
      if (!pa.v || acc_a) pa = rnd_req();
      if (!pb.v || acc_b) pb = rnd_req();
      tick();
    end
    pa = '0; pb = '0;
    tick();
    tick();
    tick();
    @(negedge clk);
    @(posedge clk);
    chk_en = 0;
    chk("drain_grants", 64'(gq.size()), 64'h0);
    chk("drain_a_reads", 64'(qa.size()), 64'h0);
    chk("drain_b_reads", 64'(qb.size()), 64'h0);

    // asynchronous reset with an A read outstanding
    #1;
    a_valid = 1; a_write = 0; a_addr = 32'h100; b_valid = 0;
    #3;
    chk("pre_rst_a_ready", 64'(a_ready), 64'h1);
    @(posedge clk);
    #1;
    a_valid = 0;
    chk("pre_rst_a_rvalid", 64'(a_rvalid), 64'h1);
    chk("pre_rst_a_rdata", 64'(a_rdata), 64'(refm[32'h40]));
    #1 rst = 1'b1;
    #1;
    chk("rst_drop_a_rvalid", 64'(a_rvalid), 64'h0);
    chk("rst_drop_a_rdata", 64'(a_rdata), 64'h0);
    a_valid = 1; b_valid = 1;
    #1;
    chk("in_rst_a_ready", 64'(a_ready), 64'h0);
    chk("in_rst_b_ready", 64'(b_ready), 64'h0);
    chk("in_rst_mem_valid", 64'(mem_valid), 64'h0);
    @(posedge clk);
    #1;
    chk("in_rst_a_rvalid", 64'(a_rvalid), 64'h0);
    #2 rst = 1'b0;
    #1;
    chk("post_rst_a_ready", 64'(a_ready), 64'h1);
    chk("post_rst_b_ready", 64'(b_ready), 64'h0);
    chk("post_rst_b1_a_ready", 64'(a_ready1), 64'h1);
    chk("post_rst_mem_addr", 64'(mem_addr), 64'h100);
    @(posedge clk);
    #1;
    a_valid = 0; b_valid = 0;
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
